// File: rtl/am2940_nibble_reader.sv
// Nibble-serial read port: captures one of four 8-bit source registers on a
// plrd falling edge and presents it low nibble first, handshaked by dready.
// Optional build macro: AM2940_RD_PARITY_EN (even parity on dpar).
module am2940_nibble_reader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       plrd,
    input  logic [1:0] sel,
    input  logic [7:0] acnt,
    input  logic [7:0] areg,
    input  logic [7:0] wcnt,
    input  logic [7:0] wreg,
    input  logic       dready,
    output logic [3:0] dout,
    output logic       dvalid,
    output logic       dpar,
    output logic       busy,
    output logic       done
);

    // state | meaning
    // IDLE  | waiting for a plrd falling edge
    // LOW   | presenting shadow[3:0] until dready
    // HIGH  | presenting shadow[7:4] until dready
    // DONE  | one-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       plrd_q;
    logic [7:0] shadow;
    logic [7:0] src_sel;
    logic       start;

    always_comb begin
        src_sel = acnt;
        case (sel)
            2'b00:   src_sel = acnt;
            2'b01:   src_sel = areg;
            2'b10:   src_sel = wcnt;
            2'b11:   src_sel = wreg;
            default: src_sel = acnt;
        endcase
    end

    // Edges seen outside IDLE are dropped, and plrd_q still tracks plrd, so a
    // strobe held low through a whole read cannot retrigger on return to IDLE.
    assign start = (state == IDLE) && !plrd && plrd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            plrd_q <= 1'b1;
            shadow <= 8'h00;
        end else begin
            state  <= state_nxt;
            plrd_q <= plrd;
            if (start) begin
                shadow <= src_sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = LOW;
            LOW:     if (dready) state_nxt = HIGH;
            HIGH:    if (dready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dout   = 4'h0;
        dvalid = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE: ;
            LOW: begin
                dout   = shadow[3:0];
                dvalid = 1'b1;
                busy   = 1'b1;
            end
            HIGH: begin
                dout   = shadow[7:4];
                dvalid = 1'b1;
                busy   = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef AM2940_RD_PARITY_EN
    assign dpar = dvalid & (^dout);
`else
    assign dpar = 1'b0;
`endif

endmodule
